// File: rtl/crc_gen.sv
// Serial CRC5/CRC16 generator: forwards the SYNC+PID+payload stream one cycle late
// and appends the complemented CRC of the payload, MSB first.
module crc_gen #(
  parameter int HDR_BITS    = 16,
  parameter int HSHAKE_BITS = 16,
  parameter int TOKEN_BITS  = 27,
  parameter int DATA_BITS   = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pkt_in,
  input  logic       s_in,
  input  logic       endr,
  output logic       s_out,
  output logic       out_valid,
  output logic       out_eop,
  output logic       busy,
  output logic       crc_err
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, HOLD} state_t;

  localparam logic [1:0] TYPE_TOKEN  = 2'b01;
  localparam logic [1:0] TYPE_HSHAKE = 2'b10;

  state_t      r_state;
  logic [1:0]  r_type;
  logic [6:0]  r_cnt;
  logic [15:0] r_crc;
  logic        r_sout;
  logic        r_valid;
  logic        r_eop;
  logic        r_err;

  logic        w_isToken;
  logic        w_isHshake;
  logic [6:0]  w_lastIdx;
  logic [6:0]  w_crcLast;
  logic        w_crcMsb;
  logic        w_fb;
  logic [15:0] w_poly;
  logic [15:0] w_crcNext;

  // Token CRC lives in r_crc[4:0]; the bits above it are don't-care for tokens.
  always_comb begin
    w_isToken  = (r_type == TYPE_TOKEN);
    w_isHshake = (r_type == TYPE_HSHAKE);
    w_lastIdx  = 7'(DATA_BITS - 1);
    w_crcLast  = 7'd15;
    w_poly     = 16'h8005;
    if (w_isToken) begin
      w_lastIdx = 7'(TOKEN_BITS - 1);
      w_crcLast = 7'd4;
      w_poly    = 16'h0005;
    end else if (w_isHshake) begin
      w_lastIdx = 7'(HSHAKE_BITS - 1);
    end
    w_crcMsb  = w_isToken ? r_crc[4] : r_crc[15];
    w_fb      = s_in ^ w_crcMsb;
    w_crcNext = {r_crc[14:0], 1'b0} ^ (w_fb ? w_poly : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_type  <= 2'b00;
      r_cnt   <= 7'd0;
      r_crc   <= 16'hFFFF;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_eop   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sout  <= 1'b0;
          r_valid <= 1'b0;
          r_eop   <= 1'b0;
          if (pkt_in != 2'b00) begin
            r_type  <= pkt_in;
            r_cnt   <= 7'd0;
            r_crc   <= 16'hFFFF;
            r_state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          // An end marker before the last bit means the encoder aborted the packet.
          if (endr) begin
            r_err   <= 1'b1;
            r_sout  <= 1'b0;
            r_valid <= 1'b0;
            r_eop   <= 1'b0;
            r_state <= HOLD;
          end else begin
            r_sout  <= s_in;
            r_valid <= 1'b1;
            r_cnt   <= r_cnt + 7'd1;
            if (r_cnt >= 7'(HDR_BITS)) r_crc <= w_crcNext;
            if (r_cnt == w_lastIdx) begin
              if (w_isHshake) begin
                r_eop   <= 1'b1;
                r_state <= HOLD;
              end else begin
                r_cnt   <= 7'd0;
                r_state <= CRC;
              end
            end
          end
        end
        CRC: begin
          r_sout  <= ~w_crcMsb;
          r_valid <= 1'b1;
          r_crc   <= {r_crc[14:0], 1'b0};
          r_cnt   <= r_cnt + 7'd1;
          if (r_cnt == w_crcLast) begin
            r_eop   <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          r_sout  <= 1'b0;
          r_valid <= 1'b0;
          r_eop   <= 1'b0;
          if (!endr) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_out     = r_sout;
  assign out_valid = r_valid;
  assign out_eop   = r_eop;
  assign crc_err   = r_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_crc_gen.sv
// Scoreboard bench for crc_gen: stimulus pushes expected bits, a negedge monitor
// pops and compares them; CRCs come from polynomial division over the payload.
module tb_crc_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pkt_in;
  logic       s_in;
  logic       endr;
  logic       s_out;
  logic       out_valid;
  logic       out_eop;
  logic       busy;
  logic       crc_err;

  typedef struct {
    logic b;
    logic e;
  } exp_t;

  exp_t expQ[$];
  logic capQ[$];
  exp_t curExp;
  int   compared   = 0;
  int   mismatched = 0;
  int   errSeen    = 0;

  crc_gen dut (
    .clk(clk), .rst(rst), .pkt_in(pkt_in), .s_in(s_in), .endr(endr),
    .s_out(s_out), .out_valid(out_valid), .out_eop(out_eop),
    .busy(busy), .crc_err(crc_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC register after shifting `len` message bits with all-ones preset:
  // remainder of (msg with top c bits inverted) * x^c modulo the generator.
  function automatic logic [15:0] crcModel(input logic [127:0] msg, input int len, input int c);
    logic [127:0] v;
    logic [127:0] g;
    v = msg & ((128'd1 << len) - 128'd1);
    for (int i = 0; i < c; i++) v[len-1-i] = ~v[len-1-i];
    v = v << c;
    g = (c == 5) ? 128'h25 : 128'h18005;
    for (int i = len + c - 1; i >= c; i--)
      if (v[i]) v = v ^ (g << (i - c));
    return (c == 5) ? {11'b0, v[4:0]} : v[15:0];
  endfunction

  function automatic int pktLen(input logic [1:0] typ);
    return (typ == 2'b10) ? 16 : (typ == 2'b01) ? 27 : 80;
  endfunction

  function automatic int crcLen(input logic [1:0] typ);
    return (typ == 2'b10) ? 0 : (typ == 2'b01) ? 5 : 16;
  endfunction

  task automatic pushExpected(input logic [1:0] typ, input logic [127:0] bits, input int abortAt);
    int n;
    int c;
    logic [15:0] crc;
    exp_t e;
    n = pktLen(typ);
    c = crcLen(typ);
    crc = crcModel(bits, n - 16, c);
    for (int k = 0; k < n; k++) begin
      if (abortAt >= 0 && k >= abortAt) break;
      e.b = bits[n-1-k];
      e.e = (c == 0 && k == n - 1 && abortAt < 0);
      expQ.push_back(e);
    end
    if (abortAt < 0)
      for (int k = 0; k < c; k++) begin
        e.b = ~crc[c-1-k];
        e.e = (k == c - 1);
        expQ.push_back(e);
      end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (crc_err) errSeen++;
      if (out_valid) begin
        capQ.push_back(s_out);
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_bit: got s_out=%0b eop=%0b, required no output", s_out, out_eop);
        end else begin
          curExp = expQ.pop_front();
          checkOutput("s_out", s_out, curExp.b);
          checkOutput("out_eop", out_eop, curExp.e);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] typ, input logic [127:0] bits,
                               input int injectAt, input int abortAt);
    int n;
    int c;
    int errStart;
    int w;
    logic [127:0] res;
    logic [15:0] resid;
    n = pktLen(typ);
    c = crcLen(typ);
    pushExpected(typ, bits, abortAt);
    capQ.delete();
    errStart = errSeen;
    pkt_in = typ;
    tick();
    pkt_in = 2'b00;
    checkOutput("busy_rise", busy, 1);
    for (int k = 0; k < n; k++) begin
      if (k == abortAt) break;
      s_in = bits[n-1-k];
      if (k == injectAt) pkt_in = 2'b11;
      tick();
      pkt_in = 2'b00;
      if (k == 0) checkOutput("first_bit_latency", out_valid, 1);
    end
    s_in = 1'b0;
    endr = 1'b1;
    if (abortAt >= 0) begin
      tick();
      checkOutput("abort_err", crc_err, 1);
      checkOutput("abort_valid_drop", out_valid, 0);
      tick();
      checkOutput("abort_err_pulse", crc_err, 0);
    end else begin
      repeat (c) tick();
      checkOutput("eop_time", out_eop, 1);
      tick();
      checkOutput("post_eop_valid", out_valid, 0);
    end
    repeat (2) tick();
    checkOutput("hold_busy", busy, 1);
    endr = 1'b0;
    w = 0;
    while (busy && w < 10) begin
      tick();
      w++;
    end
    checkOutput("return_idle", busy, 0);
    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("err_count", errSeen - errStart, (abortAt >= 0) ? 1 : 0);
    if (abortAt < 0 && c > 0) begin
      checkOutput("captured_len", capQ.size(), n + c);
      if (capQ.size() == n + c) begin
        res = '0;
        for (int k = 16; k < n + c; k++) res = {res[126:0], capQ[k]};
        resid = crcModel(res, n - 16 + c, c);
        checkOutput("crc_residual", resid, (c == 5) ? 32'h0C : 32'h800D);
      end
    end
  endtask

  task automatic resetMidCrc(input logic [127:0] bits);
    pushExpected(2'b11, bits, -1);
    pkt_in = 2'b11;
    tick();
    pkt_in = 2'b00;
    for (int k = 0; k < 80; k++) begin
      s_in = bits[79-k];
      tick();
    end
    s_in = 1'b0;
    endr = 1'b1;
    repeat (3) tick();
    checkOutput("third_crc_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("reset_outputs", {s_out, out_valid, out_eop, busy, crc_err}, 0);
    expQ.delete();
    tick();
    rst = 1'b0;
    endr = 1'b0;
    tick();
  endtask

  initial begin
    logic [127:0] bits;
    logic [1:0]   typ;
    logic [4:0]   tokCrc;
    rst = 1'b1;
    pkt_in = 2'b00;
    s_in = 1'b0;
    endr = 1'b0;
    repeat (2) tick();
    checkOutput("reset_state", {s_out, out_valid, out_eop, busy, crc_err}, 0);
    rst = 1'b0;
    tick();

    $display("[TB] handshake packet");
    applyStimulus(2'b10, 128'h01D2, -1, -1);
    tick();

    $display("[TB] token packet, zero payload");
    applyStimulus(2'b01, 128'({8'h01, 8'hE1, 11'h000}), -1, -1);
    tokCrc = '0;
    if (capQ.size() == 32)
      for (int k = 27; k < 32; k++) tokCrc = {tokCrc[3:0], capQ[k]};
    checkOutput("token_crc_bits", tokCrc, 5'b01000);
    tick();

    $display("[TB] data packet, random payload");
    bits = 128'({8'h01, 8'hC3, $urandom, $urandom});
    applyStimulus(2'b11, bits, -1, -1);
    tick();

    $display("[TB] early abort after 10 data bits");
    applyStimulus(2'b11, 128'({8'h01, 8'hC3, $urandom, $urandom}), -1, 10);
    tick();

    $display("[TB] pkt_in during token payload");
    applyStimulus(2'b01, 128'({8'h01, 8'hE1, 11'(($urandom))}), 20, -1);
    tick();

    $display("[TB] reset during CRC");
    resetMidCrc(128'({8'h01, 8'hC3, $urandom, $urandom}));
    applyStimulus(2'b10, 128'h015A, -1, -1);
    tick();

    $display("[TB] random packets");
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(2))
        0:       typ = 2'b01;
        1:       typ = 2'b10;
        default: typ = 2'b11;
      endcase
      bits = {$urandom, $urandom, $urandom, $urandom};
      bits[pktLen(typ)-1 -: 8] = 8'h01;
      applyStimulus(typ, bits, ($urandom_range(3) == 0) ? int'($urandom_range(pktLen(typ) - 1)) : -1, -1);
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/crc_gen.md
# crc_gen

Serial CRC generator sitting directly downstream of the bit-stream encoder and upstream of the bit stuffer. It takes the MSB-first serial packet stream (SYNC + PID + payload) plus the encoder's `pkt_in` start pulse and `endr` end marker. It forwards every bit unchanged, computes CRC5 (token) or CRC16 (data) over the payload bits only, and appends the complemented CRC, MSB first. Handshake packets pass through with no CRC.

## Interface
- `HDR_BITS`, 16: SYNC + PID bits at packet start; excluded from CRC.
- `HSHAKE_BITS`, 16: total serial bits of a handshake packet.
- `TOKEN_BITS`, 27: total serial bits of a token packet (11 CRC'd bits).
- `DATA_BITS`, 80: total serial bits of a data packet (64 CRC'd bits).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pkt_in`  in  2  one-cycle packet-start pulse, encoded as 01 token, 11 data, 10 handshake, 00 none.
- `s_in`  in  1  serial bit from encoder; valid on the N cycles following the `pkt_in` pulse.
- `endr`  in  1  encoder end marker; rises the cycle after the last bit and holds until the encoder releases it.
- `s_out`  out  1  serial bit to bit stuffer (payload, then CRC).
- `out_valid`  out  1  `s_out` carries a packet bit this cycle.
- `out_eop`  out  1  high with the final bit of the packet.
- `busy`  out  1  high in every state except IDLE.
- `crc_err`  out  1  one-cycle pulse on protocol violation (early `endr`).

## Operation
- States: IDLE, PAYLOAD, CRC, HOLD.
- **IDLE**
  - A non-zero `pkt_in` latches the type and sets N = 16, 27 or 80.
  - It clears the 7-bit bit counter, loads the CRC register with all ones (5 bits for token, 16 for data), and moves to PAYLOAD.
  - `pkt_in` = 00 stays in IDLE.
- **PAYLOAD**
  - Each cycle samples `s_in`, registers it to `s_out` with `out_valid`=1, and increments the counter.
  - Bits with counter ≥ `HDR_BITS` (0-based) update the CRC: fb = `s_in` ^ crc[msb]; crc = (crc<<1) ^ (fb ? poly : 0).
  - Poly constants: CRC5 = 5'b00101 (x^5+x^2+1); CRC16 = 16'h8005 (x^16+x^15+x^2+1).
  - On the Nth bit:
    - Handshake: asserts `out_eop` with that bit, then goes to HOLD.
    - Token/data: goes to CRC.
- **CRC**
  - Shifts out ~crc, MSB first: 5 bits for token, 16 for data, with `out_valid`=1 throughout.
  - `out_eop` is asserted with the last CRC bit, then the state goes to HOLD.
- **HOLD**
  - Outputs idle.
  - Returns to IDLE on the first cycle `endr`=0.
- Early `endr`: `endr`=1 while in PAYLOAD before N bits are counted aborts the packet.
  - `crc_err` pulses and `out_valid` drops the next cycle.
  - No `out_eop` is issued; the state goes to HOLD.
- `pkt_in` ≠ 00 in any state other than IDLE is ignored. It does not restart the packet and does not raise an error.
- `endr` during CRC or HOLD is normal and is not an error.

## Timing
- Reset (async, any state, mid-packet included):
  - State returns to IDLE.
  - `s_out`, `out_valid`, `out_eop`, `busy`, `crc_err` are 0.
  - Counter is 0; CRC register is all ones.
- Let `pkt_in` pulse at cycle T and input bits arrive at T+1..T+N.
  - `s_out` bit k appears at T+1+k for k = 1..N (fixed 1-cycle latency).
  - CRC bits appear at T+N+2 .. T+N+1+C, where C = 5 for token and 16 for data.
  - `out_eop` is at T+N+1+C; for handshake (C=0) it is at T+17.
- `out_valid` is continuous from first bit to `out_eop`, with no gap between payload and CRC.
- `busy` rises at T+1 and falls the cycle after HOLD sees `endr`=0.
- A new `pkt_in` is accepted the first cycle the block is back in IDLE. The encoder's turnaround guarantees at least one idle cycle between packets.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Handshake `pkt_in`=10, stream 8'h01 then 8'hD2 -> exactly 16 bits out, identical to input and delayed 1 cycle; `out_eop` on bit 16; no CRC bits; HOLD until `endr`=0.
- Token `pkt_in`=01, SYNC 8'h01, PID 8'hE1, 11 zero payload bits -> 27 bits echoed, then CRC bits 0,1,0,0,0; `out_eop` on the 32nd bit.
- Data `pkt_in`=11, random 64-bit payload -> 80 bits echoed plus 16 CRC bits. Re-running CRC16 (init ones) over payload+transmitted CRC yields residual 16'h800D; CRC5 token case yields 5'b01100.
- Early abort: `endr`=1 after 10 data bits -> `crc_err` pulses once, `out_valid`=0 the next cycle, no `out_eop`, IDLE after `endr` falls.
- `pkt_in`=11 asserted in the middle of a token packet -> ignored; token completes with the correct CRC and `crc_err`=0.
- `rst`=1 mid-CRC (data packet, third CRC bit) -> all outputs 0 immediately; after release, a handshake packet processes correctly.
